// File: rtl/alu_regbank_seq_pkg.sv
// Shared types and encodings for the ALU operand/writeback sequencer.
// Imported by the top module and its register bank.
package alu_regbank_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC_LO = 2'd1,
        ST_EXEC_HI = 2'd2
    } state_t;

    // ALUOP encodings for the arithmetic unit (l = 0)
    localparam logic [1:0] ALU_MOV = 2'b00;
    localparam logic [1:0] ALU_INC = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_B   = 2'b11;

    typedef struct packed {
        logic z;
        logic s;
        logic c;
    } flags_t;

    // True in the cycle whose closing edge performs the last write of an instruction
    function automatic logic is_final_pass(input state_t st, input logic wide_op);
        return (st == ST_EXEC_HI) || ((st == ST_EXEC_LO) && !wide_op);
    endfunction

endpackage

// File: rtl/alu_regbank_seq_regbank_2r1w.sv
// NREG x 4-bit register bank: two operand read ports, one debug read port,
// one synchronous write port, cleared by the asynchronous active-low reset.
module regbank_2r1w
    import alu_regbank_seq_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic [AW-1:0] ra_a,
    output logic [3:0]    rd_a,
    input  logic [AW-1:0] ra_b,
    output logic [3:0]    rd_b,
    input  logic [AW-1:0] ra_dbg,
    output logic [3:0]    rd_dbg
);

    logic [3:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= 4'd0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads return pre-edge contents, so a source equal to the destination is safe
    assign rd_a   = mem[ra_a];
    assign rd_b   = mem[ra_b];
    assign rd_dbg = mem[ra_dbg];

endmodule

// File: rtl/alu_regbank_seq.sv
// Operand/writeback stage around a 4-bit combinational ALU: single-nibble ops
// in one pass, 8-bit ops over register pairs in two passes with chained carry.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for start; direct loads accepted; ALU inputs parked at 0
// ST_EXEC_LO | narrow op, or low nibble of a wide op
// ST_EXEC_HI | high nibble of a wide op, carry-in from the low pass
module alu_regbank_seq
    import alu_regbank_seq_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    alu_op_i,
    input  logic          l_i,
    input  logic          wide,
    input  logic          use_c,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [3:0]    ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data,
    output logic          busy,
    output logic          done,
    output logic [3:0]    alu_A,
    output logic [3:0]    alu_B,
    output logic          alu_cin,
    output logic [1:0]    alu_op,
    output logic          alu_l,
    input  logic [3:0]    alu_R,
    input  logic          alu_zero,
    input  logic          alu_sign,
    input  logic          alu_cout,
    output logic          flag_z,
    output logic          flag_s,
    output logic          flag_c
);

    localparam logic [AW-1:0] PAIR_LSB = AW'(1);

    state_t        state;
    state_t        state_nxt;

    logic [1:0]    op_q;
    logic          l_q;
    logic          wide_q;
    logic          use_c_q;
    logic          we_q;
    logic [AW-1:0] ra1_q;
    logic [AW-1:0] ra2_q;
    logic [AW-1:0] wa_q;

    logic          cint_q;
    logic          zlo_q;
    logic          done_q;
    flags_t        flags_q;

    logic          accept;
    logic          ld_ok;
    logic          exec;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-1:0] addr_w;
    logic          bank_wen;
    logic [AW-1:0] bank_waddr;
    logic [3:0]    bank_wdata;
    logic [3:0]    opnd_a;
    logic [3:0]    opnd_b;

    assign accept = (state == ST_IDLE) && start;
    assign ld_ok  = (state == ST_IDLE) && !start && ld_en;
    assign exec   = (state != ST_IDLE);

    // Wide ops address the even register of a pair first, then the odd one
    always_comb begin
        addr_a = ra1_q;
        addr_b = ra2_q;
        addr_w = wa_q;
        if (state == ST_EXEC_HI) begin
            addr_a = ra1_q | PAIR_LSB;
            addr_b = ra2_q | PAIR_LSB;
            addr_w = wa_q  | PAIR_LSB;
        end else if (wide_q) begin
            addr_a = ra1_q & ~PAIR_LSB;
            addr_b = ra2_q & ~PAIR_LSB;
            addr_w = wa_q  & ~PAIR_LSB;
        end
    end

    assign bank_wen   = (exec && we_q) || ld_ok;
    assign bank_waddr = exec ? addr_w : ld_addr;
    assign bank_wdata = exec ? alu_R  : ld_data;

    regbank_2r1w #(
        .NREG (NREG),
        .AW   (AW)
    ) u_bank (
        .clk     (clk),
        .rst_n   (reset_n),
        .wr_en   (bank_wen),
        .wr_addr (bank_waddr),
        .wr_data (bank_wdata),
        .ra_a    (addr_a),
        .rd_a    (opnd_a),
        .ra_b    (addr_b),
        .rd_b    (opnd_b),
        .ra_dbg  (rd_addr),
        .rd_dbg  (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_EXEC_LO;
            ST_EXEC_LO: state_nxt = wide_q ? ST_EXEC_HI : ST_IDLE;
            ST_EXEC_HI: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        alu_A   = 4'd0;
        alu_B   = 4'd0;
        alu_cin = 1'b0;
        alu_op  = 2'b00;
        alu_l   = 1'b0;
        case (state)
            ST_EXEC_LO: begin
                busy    = 1'b1;
                alu_A   = opnd_a;
                alu_B   = opnd_b;
                alu_cin = use_c_q & flags_q.c;
                alu_op  = op_q;
                alu_l   = l_q;
            end
            ST_EXEC_HI: begin
                busy    = 1'b1;
                alu_A   = opnd_a;
                alu_B   = opnd_b;
                alu_cin = l_q ? 1'b0 : cint_q;
                alu_op  = op_q;
                alu_l   = l_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= 2'b00;
            l_q     <= 1'b0;
            wide_q  <= 1'b0;
            use_c_q <= 1'b0;
            we_q    <= 1'b0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            wa_q    <= '0;
        end else if (accept) begin
            op_q    <= alu_op_i;
            l_q     <= l_i;
            wide_q  <= wide;
            use_c_q <= use_c;
            we_q    <= we;
            ra1_q   <= ra1;
            ra2_q   <= ra2;
            wa_q    <= wa;
        end
    end

    // Logic-unit ops never disturb the carry flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
            cint_q  <= 1'b0;
            zlo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= is_final_pass(state, wide_q);
            case (state)
                ST_EXEC_LO: begin
                    if (wide_q) begin
                        cint_q <= alu_cout;
                        zlo_q  <= alu_zero;
                    end else begin
                        flags_q.z <= alu_zero;
                        flags_q.s <= alu_sign;
                        if (!l_q) flags_q.c <= alu_cout;
                    end
                end
                ST_EXEC_HI: begin
                    flags_q.z <= zlo_q & alu_zero;
                    flags_q.s <= alu_sign;
                    if (!l_q) flags_q.c <= alu_cout;
                end
                default: begin
                    flags_q <= flags_q;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign flag_z = flags_q.z;
    assign flag_s = flags_q.s;
    assign flag_c = flags_q.c;

endmodule

// File: tb/tb_alu_regbank_seq.sv
// Directed bench for alu_regbank_seq with a behavioural 4-bit ALU and a
// scoreboard checked whenever the sequencer pulses done.
module tb_alu_regbank_seq;
    import alu_regbank_seq_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] alu_op_i;
    logic       l_i;
    logic       wide;
    logic       use_c;
    logic [2:0] ra1, ra2, wa;
    logic       we;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [3:0] ld_data;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;
    logic       busy, done;
    logic [3:0] alu_A, alu_B;
    logic       alu_cin;
    logic [1:0] alu_op;
    logic       alu_l;
    logic [3:0] alu_R;
    logic       alu_zero, alu_sign, alu_cout;
    logic       flag_z, flag_s, flag_c;

    alu_regbank_seq #(.NREG(8), .AW(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .alu_op_i (alu_op_i),
        .l_i      (l_i),
        .wide     (wide),
        .use_c    (use_c),
        .ra1      (ra1),
        .ra2      (ra2),
        .wa       (wa),
        .we       (we),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_cin  (alu_cin),
        .alu_op   (alu_op),
        .alu_l    (alu_l),
        .alu_R    (alu_R),
        .alu_zero (alu_zero),
        .alu_sign (alu_sign),
        .alu_cout (alu_cout),
        .flag_z   (flag_z),
        .flag_s   (flag_s),
        .flag_c   (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: l=0 MOV(A+cin)/INC(A+1)/ADD(A+B+cin)/B(B+cin); l=1 AND/OR/XOR/NOT, no carry
    logic [4:0] sum;
    always_comb begin
        sum = 5'd0;
        if (!alu_l) begin
            case (alu_op)
                ALU_MOV: sum = {1'b0, alu_A} + {4'd0, alu_cin};
                ALU_INC: sum = {1'b0, alu_A} + 5'd1;
                ALU_ADD: sum = {1'b0, alu_A} + {1'b0, alu_B} + {4'd0, alu_cin};
                default: sum = {1'b0, alu_B} + {4'd0, alu_cin};
            endcase
        end else begin
            case (alu_op)
                2'b00:   sum = {1'b0, alu_A & alu_B};
                2'b01:   sum = {1'b0, alu_A | alu_B};
                2'b10:   sum = {1'b0, alu_A ^ alu_B};
                default: sum = {1'b0, ~alu_A};
            endcase
        end
    end
    assign alu_R    = sum[3:0];
    assign alu_cout = sum[4];
    assign alu_zero = (sum[3:0] == 4'd0);
    assign alu_sign = sum[3];

    typedef struct {
        int         id;
        logic       wide;
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic [2:0] flags;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: on every done pulse, pop one expectation and compare flags and bank contents
    initial begin
        exp_t e;
        logic [2:0] hi_addr;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 8'd1, 8'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("op%0d_flags_zsc", e.id), {5'd0, flag_z, flag_s, flag_c}, {5'd0, e.flags});
                    if (e.we) begin
                        rd_addr = e.addr;
                        #1;
                        check($sformatf("op%0d_lo_nibble", e.id), {4'd0, rd_data}, {4'd0, e.data[3:0]});
                        if (e.wide) begin
                            hi_addr = e.addr + 3'd1;
                            rd_addr = hi_addr;
                            #1;
                            check($sformatf("op%0d_hi_nibble", e.id), {4'd0, rd_data}, {4'd0, e.data[7:4]});
                        end
                    end
                end
            end
        end
    end

    task automatic ld(input logic [2:0] a, input logic [3:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [3:0] exp);
        @(posedge clk);
        #2;
        rd_addr = a;
        #1;
        check(name, {4'd0, rd_data}, {4'd0, exp});
    endtask

    // Leaves the bench at the negedge after the accepting edge (state EXEC_LO)
    task automatic issue(input int id, input logic [1:0] op, input logic l, input logic wd,
                         input logic uc, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] w, input logic push,
                         input logic [7:0] edata, input logic [2:0] eflags);
        exp_t e;
        @(negedge clk);
        start = 1'b1; alu_op_i = op; l_i = l; wide = wd; use_c = uc;
        ra1 = a1; ra2 = a2; wa = w; we = 1'b1;
        if (push) begin
            e.id = id; e.wide = wd; e.we = 1'b1; e.addr = w & 3'b110;
            if (!wd) e.addr = w;
            e.data = edata; e.flags = eflags;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int id, input logic wd);
        int cyc = 0;
        while (busy && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        check($sformatf("op%0d_busy_cycles", id), 8'(cyc), wd ? 8'd2 : 8'd1);
        check($sformatf("op%0d_done_pulse", id), {7'd0, done}, 8'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; alu_op_i = 2'b00; l_i = 1'b0; wide = 1'b0;
        use_c = 1'b0; ra1 = '0; ra2 = '0; wa = '0; we = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        check("reset_flags", {5'd0, flag_z, flag_s, flag_c}, 8'd0);
        check("reset_alu_drive", {alu_A, alu_op, alu_cin, alu_l}, 8'd0);
        rd_chk("reset_r3", 3'd3, 4'd0);

        // Reset during EXEC_LO aborts the increment of r0
        ld(3'd0, 4'd5);
        rd_chk("load_r0", 3'd0, 4'd5);
        issue(0, ALU_INC, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 3'b000);
        check("abort_in_exec", {7'd0, busy}, 8'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_flags", {5'd0, flag_z, flag_s, flag_c}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_chk("abort_r0", 3'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {7'd0, done}, 8'd0);
        end

        // 7 + 9 = 0x10
        ld(3'd1, 4'h7); ld(3'd2, 4'h9);
        issue(1, ALU_ADD, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 8'h00, 3'b101);
        wait_done(1, 1'b0);

        // 2 + 3 + carry = 6
        ld(3'd1, 4'h2); ld(3'd2, 4'h3);
        issue(2, ALU_ADD, 1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 8'h06, 3'b000);
        wait_done(2, 1'b0);

        // 0x3F + 0x01 = 0x40; odd LSBs on operands must be ignored
        ld(3'd4, 4'hF); ld(3'd5, 4'h3); ld(3'd6, 4'h1); ld(3'd7, 4'h0);
        issue(3, ALU_ADD, 1'b0, 1'b1, 1'b0, 3'd5, 3'd6, 3'd4, 1'b1, 8'h40, 3'b000);
        wait_done(3, 1'b1);

        // 0xFF + 0x01 = 0x100
        ld(3'd4, 4'hF); ld(3'd5, 4'hF); ld(3'd6, 4'h1); ld(3'd7, 4'h0);
        issue(4, ALU_ADD, 1'b0, 1'b1, 1'b0, 3'd4, 3'd6, 3'd4, 1'b1, 8'h00, 3'b101);
        wait_done(4, 1'b1);

        // 0x01 + 0x01 into r1:r0, with a start and a load fired into EXEC_HI
        issue(5, ALU_ADD, 1'b0, 1'b1, 1'b0, 3'd6, 3'd6, 3'd0, 1'b1, 8'h02, 3'b000);
        @(negedge clk);
        check("collide_in_hi", {7'd0, busy}, 8'd1);
        start = 1'b1; alu_op_i = ALU_B; l_i = 1'b0; wide = 1'b0; use_c = 1'b0;
        ra1 = 3'd6; ra2 = 3'd6; wa = 3'd2; we = 1'b1;
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 4'hA;
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        check("op5_done_pulse", {7'd0, done}, 8'd1);
        @(negedge clk);
        check("collide_not_queued", {7'd0, busy}, 8'd0);
        rd_chk("collide_r2_kept", 3'd2, 4'h3);
        rd_chk("busy_load_r7_kept", 3'd7, 4'h0);

        // 0xF + 0x8 sets carry; then AND must leave it set
        ld(3'd1, 4'hF); ld(3'd2, 4'h8);
        issue(6, ALU_ADD, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 8'h07, 3'b001);
        wait_done(6, 1'b0);
        issue(7, 2'b00, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1, 8'h08, 3'b011);
        wait_done(7, 1'b0);

        // In-place increment reads the old value of r3
        issue(8, ALU_INC, 1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 3'd3, 1'b1, 8'h09, 3'b010);
        wait_done(8, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
